alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 134 +++++++++++++
 tb/tb_alu_arbiter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared combinational ALU.
// Each accepted request runs IDLE -> EXEC -> RESP, and the response is held until it is acknowledged.
module alu_arbiter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic             req1_valid,
  input  logic [31:0]      req0_a,
  input  logic [31:0]      req0_b,
  input  logic [31:0]      req1_a,
  input  logic [31:0]      req1_b,
  input  logic [2:0]       req0_op,
  input  logic [2:0]       req1_op,
  output logic             req0_ready,
  output logic             req1_ready,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic [2:0]       alu_op,
  input  logic [31:0]      alu_ans,
  output logic             resp_valid,
  output logic             resp_id,
  output logic [31:0]      resp_data,
  output logic             resp_err,
  input  logic             resp_ack,
  output logic             busy,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t             state_q, state_d;
  logic               ptr_q, ptr_d;
  logic [31:0]        a_q, a_d;
  logic [31:0]        b_q, b_d;
  logic [2:0]         op_q, op_d;
  logic               id_q, id_d;
  logic [31:0]        data_q, data_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   cnt0_q, cnt0_d;
  logic [CNT_W-1:0]   cnt1_q, cnt1_d;
  logic               gnt0, gnt1;

  // Handshake: a request transfers on the edge where reqN_valid && reqN_ready.
  // The response transfers on the edge where resp_valid && resp_ack.
  // ptr_q names the requester granted last; on a tie the other one wins.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    id_d       = id_q;
    data_d     = data_q;
    err_d      = err_q;
    cnt0_d     = cnt0_q;
    cnt1_d     = cnt1_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    gnt0       = req0_valid && (!req1_valid || ptr_q);
    gnt1       = req1_valid && (!req0_valid || !ptr_q);
    case (state_q)
      IDLE: begin
        req0_ready = gnt0 && reset;
        req1_ready = gnt1 && reset;
        if (gnt0 || gnt1) begin
          a_d     = gnt1 ? req1_a  : req0_a;
          b_d     = gnt1 ? req1_b  : req0_b;
          op_d    = gnt1 ? req1_op : req0_op;
          id_d    = gnt1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        // Opcodes above 010 are unsupported; the ALU's answer is discarded.
        err_d   = (op_q > 3'd2);
        data_d  = (op_q > 3'd2) ? 32'd0 : alu_ans;
        state_d = RESP;
      end
      RESP: begin
        if (resp_ack) begin
          state_d = IDLE;
          ptr_d   = id_q;
          if (id_q) begin
            if (cnt1_q != {CNT_W{1'b1}}) cnt1_d = cnt1_q + CNT_W'(1);
          end else begin
            if (cnt0_q != {CNT_W{1'b1}}) cnt0_d = cnt0_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ptr_q   <= 1'b1;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      id_q    <= 1'b0;
      data_q  <= '0;
      err_q   <= 1'b0;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      id_q    <= id_d;
      data_q  <= data_d;
      err_q   <= err_d;
      cnt0_q  <= cnt0_d;
      cnt1_q  <= cnt1_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_id    = id_q;
  assign resp_data  = data_q;
  assign resp_err   = err_q;
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_op     = op_q;
  assign cnt0       = cnt0_q;
  assign cnt1       = cnt1_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: transaction-level reference model with per-cycle compare,
// plus hand-computed literal expectations for each scenario.
module tb_alu_arbiter;
  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             req0_valid, req1_valid;
  logic [31:0]      req0_a, req0_b, req1_a, req1_b;
  logic [2:0]       req0_op, req1_op;
  logic             req0_ready, req1_ready;
  logic [31:0]      alu_a, alu_b, alu_ans;
  logic [2:0]       alu_op;
  logic             resp_valid, resp_id, resp_err, resp_ack, busy;
  logic [31:0]      resp_data;
  logic [CNT_W-1:0] cnt0, cnt1;

  int n_checks = 0;
  int n_pass   = 0;

  alu_arbiter #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .req0_op(req0_op), .req1_op(req1_op),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_ans(alu_ans),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_data(resp_data),
    .resp_err(resp_err), .resp_ack(resp_ack), .busy(busy),
    .cnt0(cnt0), .cnt1(cnt1)
  );

  always #5 clk = ~clk;

  // Shared ALU; unsupported opcodes return a marker the DUT must discard.
  always_comb begin
    case (alu_op)
      3'd0:    alu_ans = alu_a + alu_b;
      3'd1:    alu_ans = alu_a - alu_b;
      3'd2:    alu_ans = alu_a | alu_b;
      default: alu_ans = 32'h1234;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Expected response for an operation: {err, data}.
  function automatic logic [32:0] expect_result(input logic [31:0] a, input logic [31:0] b,
                                                 input logic [2:0] op);
    case (op)
      3'd0:    return {1'b0, a + b};
      3'd1:    return {1'b0, a - b};
      3'd2:    return {1'b0, a | b};
      default: return {1'b1, 32'd0};
    endcase
  endfunction

  // Model: exp_q holds the outstanding response {id, err, data}; m_age counts cycles since accept.
  logic [33:0] exp_q[$];
  int          m_age;
  logic        m_last;
  int          m_cnt[2];
  logic [31:0] m_a, m_b;
  logic [2:0]  m_op;
  logic        e0, e1, e_valid;
  logic        hid;

  initial begin
    m_age = 0; m_last = 1'b1; m_cnt[0] = 0; m_cnt[1] = 0;
    m_a = '0; m_b = '0; m_op = '0;
  end

  always @(negedge clk) begin
    if (!reset) begin
      exp_q.delete();
      m_age = 0; m_last = 1'b1; m_cnt[0] = 0; m_cnt[1] = 0;
      m_a = '0; m_b = '0; m_op = '0;
    end
    e0 = 1'b0;
    e1 = 1'b0;
    if (reset && exp_q.size() == 0) begin
      e0 = req0_valid && (!req1_valid || m_last == 1'b1);
      e1 = req1_valid && (!req0_valid || m_last == 1'b0);
    end
    e_valid = (exp_q.size() != 0) && (m_age >= 2);
    check("req0_ready", 32'(req0_ready), 32'(e0));
    check("req1_ready", 32'(req1_ready), 32'(e1));
    check("busy", 32'(busy), 32'(exp_q.size() != 0));
    check("resp_valid", 32'(resp_valid), 32'(e_valid));
    if (e_valid) begin
      check("resp_id", 32'(resp_id), 32'(exp_q[0][33]));
      check("resp_err", 32'(resp_err), 32'(exp_q[0][32]));
      check("resp_data", resp_data, exp_q[0][31:0]);
    end
    check("cnt0", 32'(cnt0), 32'(m_cnt[0]));
    check("cnt1", 32'(cnt1), 32'(m_cnt[1]));
    check("alu_a", alu_a, m_a);
    check("alu_b", alu_b, m_b);
    check("alu_op", 32'(alu_op), 32'(m_op));
    if (reset) begin
      if (exp_q.size() == 0) begin
        if (e0 || e1) begin
          m_a  = e1 ? req1_a  : req0_a;
          m_b  = e1 ? req1_b  : req0_b;
          m_op = e1 ? req1_op : req0_op;
          exp_q.push_back({e1, expect_result(m_a, m_b, m_op)});
          m_age = 1;
        end
      end else if (m_age < 2) begin
        m_age++;
      end else if (resp_ack) begin
        hid = exp_q[0][33];
        m_last = hid;
        if (m_cnt[hid] < CNT_MAX) m_cnt[hid]++;
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    req0_valid = 0; req1_valid = 0; resp_ack = 0;
    req0_a = 0; req0_b = 0; req0_op = 0;
    req1_a = 0; req1_b = 0; req1_op = 0;
  endtask

  task automatic do_reset;
    clear_inputs();
    reset = 0;
    tick();
    tick();
    reset = 1;
  endtask

  logic        got_id[4];
  logic [31:0] got_data[4];
  int          got_n;

  initial begin
    clear_inputs();
    reset = 1;
    #1 reset = 0;
    @(posedge clk);
    #1;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    tick();
    reset = 1;

    // Single request: 5 + 3
    req0_valid = 1; req0_a = 5; req0_b = 3; req0_op = 3'd0; resp_ack = 1;
    #1 check("s1_ready0", 32'(req0_ready), 32'd1);
    tick();
    req0_valid = 0;
    tick();
    check("s1_valid", 32'(resp_valid), 32'd1);
    check("s1_id", 32'(resp_id), 32'd0);
    check("s1_data", resp_data, 32'd8);
    check("s1_err", 32'(resp_err), 32'd0);
    tick();
    check("s1_cnt0", 32'(cnt0), 32'd1);
    check("s1_valid_drop", 32'(resp_valid), 32'd0);

    // Tie fairness
    do_reset();
    req0_valid = 1; req0_op = 3'd1; req0_a = 10;    req0_b = 4;
    req1_valid = 1; req1_op = 3'd2; req1_a = 32'hF0; req1_b = 32'h0F;
    resp_ack = 1;
    got_n = 0;
    for (int i = 0; i < 12; i++) begin
      if (resp_valid && got_n < 4) begin
        got_id[got_n] = resp_id;
        got_data[got_n] = resp_data;
        got_n++;
      end
      tick();
    end
    req0_valid = 0; req1_valid = 0;
    check("tie_count", 32'(got_n), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < got_n) begin
        check("tie_id", 32'(got_id[i]), 32'(i % 2));
        check("tie_data", got_data[i], (i % 2 == 0) ? 32'd6 : 32'hFF);
      end
    end
    check("tie_cnt0", 32'(cnt0), 32'd2);
    check("tie_cnt1", 32'(cnt1), 32'd2);

    // Response backpressure
    do_reset();
    req0_valid = 1; req0_a = 1; req0_b = 2; req0_op = 3'd0;
    tick();
    req0_valid = 0;
    req1_valid = 1; req1_a = 7; req1_b = 7; req1_op = 3'd0;
    tick();
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 32'(resp_valid), 32'd1);
      check("bp_data", resp_data, 32'd3);
      check("bp_ready1", 32'(req1_ready), 32'd0);
      tick();
    end
    resp_ack = 1;
    #1 check("bp_ready1_ack", 32'(req1_ready), 32'd0);
    tick();
    resp_ack = 0;
    #1 check("bp_ready1_after", 32'(req1_ready), 32'd1);
    tick();
    req1_valid = 0;
    tick();
    tick();
    check("bp_id1", 32'(resp_id), 32'd1);
    check("bp_data1", resp_data, 32'd14);
    resp_ack = 1;
    tick();

    // Unsupported opcode
    do_reset();
    req1_valid = 1; req1_a = 1; req1_b = 2; req1_op = 3'd7; resp_ack = 1;
    tick();
    req1_valid = 0;
    tick();
    check("bad_err", 32'(resp_err), 32'd1);
    check("bad_data", resp_data, 32'd0);
    check("bad_id", 32'(resp_id), 32'd1);
    tick();
    check("bad_cnt1", 32'(cnt1), 32'd1);

    // Reset during EXEC
    do_reset();
    req0_valid = 1; req0_a = 9; req0_b = 9; req0_op = 3'd0; resp_ack = 1;
    tick();
    req0_valid = 0;
    reset = 0;
    #1;
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_valid", 32'(resp_valid), 32'd0);
    check("mid_cnt0", 32'(cnt0), 32'd0);
    check("mid_alu_a", alu_a, 32'd0);
    tick();
    tick();
    reset = 1;
    req0_valid = 1; req0_a = 2; req0_b = 2; req0_op = 3'd0;
    req1_valid = 1; req1_a = 3; req1_b = 1; req1_op = 3'd1;
    #1;
    check("mid_ready0", 32'(req0_ready), 32'd1);
    check("mid_ready1", 32'(req1_ready), 32'd0);
    tick();
    req0_valid = 0; req1_valid = 0;
    tick();
    tick();
    check("mid_resp_id", 32'(resp_id), 32'd0);
    check("mid_resp_data", resp_data, 32'd4);
    tick();

    // Counter saturation
    do_reset();
    resp_ack = 1;
    for (int i = 0; i < 7; i++) begin
      req0_valid = 1; req0_a = 32'(i); req0_b = 1; req0_op = 3'd0;
      tick();
      req0_valid = 0;
      tick();
      tick();
      if (i == 1) check("sat_cnt0_2", 32'(cnt0), 32'd2);
    end
    check("sat_cnt0", 32'(cnt0), 32'd3);
    check("sat_cnt1", 32'(cnt1), 32'd0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
